shift_reg: RTL and testbench

//   Parameterised universal shift register with a 2-bit mode control.
//   Per clock it holds, shifts right, shifts left or parallel-loads from d.

---
 rtl/shift_reg.sv | 65 ++++++
 tb/tb_shift_reg.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/shift_reg.sv
// shift_reg: universal shift register with hold / shift right / shift left / load.
// Shift modes take their serial fill bits from the d bus.
// Optional build macro SHIFT_REG_ROTATE_EN: when defined, the shift modes rotate
// the register contents and ignore d; hold, load and reset are unchanged.
module shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       cntrl,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next-state selection; any cntrl value that is not a known mode (X/Z) falls to hold.
    always_comb begin
        q_d = q_q;
        case (cntrl)
            MODE_HOLD: begin
                q_d = q_q;
            end
            MODE_RIGHT: begin
`ifdef SHIFT_REG_ROTATE_EN
                q_d = {q_q[0], q_q[WIDTH-1:1]};
`else
                q_d = {d[WIDTH-1], q_q[WIDTH-1:1]};
`endif
            end
            MODE_LEFT: begin
`ifdef SHIFT_REG_ROTATE_EN
                q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
`else
                q_d = {q_q[WIDTH-2:0], d[0]};
`endif
            end
            MODE_LOAD: begin
                q_d = d;
            end
            default: begin
                q_d = q_q;
            end
        endcase
    end

    // State register; asynchronous reset clears the contents immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    // Output comes straight from the register: no combinational input-to-output path.
    assign q = q_q;

endmodule

// File: tb/tb_shift_reg.sv
// tb_shift_reg: directed and randomized checks of shift_reg (WIDTH=4).
// Honours SHIFT_REG_ROTATE_EN the same way the design does.
module tb_shift_reg;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic [1:0]   cntrl;
    logic [W-1:0] d;
    logic [W-1:0] q;

    int total;
    int bad;

    shift_reg #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .cntrl (cntrl),
        .d     (d),
        .q     (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: register value treated as an integer, updated with shifts, ors and masks.
    function automatic logic [W-1:0] ref_next(input logic [W-1:0] cur,
                                              input logic [1:0]   c,
                                              input logic [W-1:0] dv);
        int v;
        int mask;
        int cv;
        int dd;
        mask = (1 << W) - 1;
        cv   = int'(cur);
        dd   = int'(dv);
        case (c)
            2'd1: begin
`ifdef SHIFT_REG_ROTATE_EN
                v = (cv >> 1) | ((cv & 1) << (W - 1));
`else
                v = (cv >> 1) | (((dd >> (W - 1)) & 1) << (W - 1));
`endif
            end
            2'd2: begin
`ifdef SHIFT_REG_ROTATE_EN
                v = ((cv << 1) | ((cv >> (W - 1)) & 1)) & mask;
`else
                v = ((cv << 1) | (dd & 1)) & mask;
`endif
            end
            2'd3:    v = dd;
            default: v = cv;
        endcase
        return v[W-1:0];
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: q=%b expected %b", tag, obs, exp);
        end
    endtask

    // Apply one mode/data pair, clock once, and check q shortly after the edge.
    task automatic step(input logic [1:0] c, input logic [W-1:0] dv,
                        input logic [W-1:0] exp, input string tag);
        cntrl = c;
        d     = dv;
        @(posedge clk);
        #1;
        check(tag, q, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic [W-1:0] m;
    logic [1:0]   rc;
    logic [W-1:0] rd;
    logic [W-1:0] e;

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        cntrl = 2'b00;
        d     = '0;

        // reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_state", q, 4'b0000);
        reset = 1'b0;

        // asynchronous reset between edges, then held across edges
        step(2'b11, 4'b1011, 4'b1011, "load_1011");
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", q, 4'b0000);
        cntrl = 2'b11;
        d     = 4'b1111;
        @(posedge clk);
        #1;
        check("reset_hold1", q, 4'b0000);
        @(posedge clk);
        #1;
        check("reset_hold2", q, 4'b0000);
        reset = 1'b0;

        // load then hold
        step(2'b11, 4'b0110, 4'b0110, "load_0110");
        step(2'b00, 4'b1111, 4'b0110, "hold1");
        step(2'b00, 4'b1111, 4'b0110, "hold2");
        step(2'b00, 4'b1111, 4'b0110, "hold3");

        // reset coinciding with a clock edge that would otherwise load
        cntrl = 2'b11;
        d     = 4'b1111;
        @(posedge clk);
        reset = 1'b1;
        #1;
        check("reset_at_edge", q, 4'b0000);
        reset = 1'b0;

`ifndef SHIFT_REG_ROTATE_EN
        // shift right with MSB fill from d
        do_reset();
        step(2'b01, 4'b1000, 4'b1000, "shr1");
        step(2'b01, 4'b1000, 4'b1100, "shr2");
        step(2'b01, 4'b1000, 4'b1110, "shr3");
        step(2'b01, 4'b1000, 4'b1111, "shr4");
        step(2'b01, 4'b0000, 4'b0111, "shr_fill0");

        // shift left with LSB fill from d
        do_reset();
        step(2'b10, 4'b0001, 4'b0001, "shl1");
        step(2'b10, 4'b0001, 4'b0011, "shl2");
        step(2'b10, 4'b0001, 4'b0111, "shl3");
        step(2'b10, 4'b0001, 4'b1111, "shl4");
        step(2'b10, 4'b0000, 4'b1110, "shl_fill0");

        // mode sequence: right shifts see d[3]=0, left shifts see d[0]=1
        do_reset();
        step(2'b01, 4'b0001, 4'b0000, "seq_r1");
        step(2'b01, 4'b0001, 4'b0000, "seq_r2");
        step(2'b01, 4'b0001, 4'b0000, "seq_r3");
        step(2'b10, 4'b0001, 4'b0001, "seq_l1");
        step(2'b10, 4'b0001, 4'b0011, "seq_l2");
        step(2'b10, 4'b0001, 4'b0111, "seq_l3");
`else
        // rotate build: d toggles during shifts and must not matter
        step(2'b11, 4'b0001, 4'b0001, "rot_load");
        step(2'b01, 4'b1111, 4'b1000, "rot_r1");
        step(2'b01, 4'b0000, 4'b0100, "rot_r2");
        step(2'b10, 4'b1111, 4'b1000, "rot_l1");
        step(2'b10, 4'b0000, 4'b0001, "rot_l2");
        step(2'b10, 4'b1110, 4'b0010, "rot_l3");
        step(2'b01, 4'b0111, 4'b0001, "rot_r3");
`endif

        // randomized modes and data against the reference, with occasional async resets
        do_reset();
        m = '0;
        for (int i = 0; i < 300; i++) begin
            rc = 2'($urandom_range(0, 3));
            rd = 4'($urandom);
            e  = ref_next(m, rc, rd);
            step(rc, rd, e, "random");
            m = e;
            if ($urandom_range(0, 19) == 0) begin
                reset = 1'b1;
                #1;
                check("random_reset", q, 4'b0000);
                reset = 1'b0;
                m = '0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
